// File: rtl/ksa_mp_sequencer.sv
// Multi-precision add/subtract sequencer that time-shares one 32-bit Kogge-Stone adder across operand words.
// Optional feature: define KSA_SEQ_ABORT_EN to add the abort input.

module koggestone32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cIn,
    output logic [31:0] sum,
    output logic        cOut
);

    wire [5:0][31:0] g;
    wire [5:0][31:0] p;
    wire [32:0]      c;

    assign g[0] = a & b;
    assign p[0] = a ^ b;

    // Five prefix levels; after level 5 bit i holds group generate/propagate over [i:0]
    for (genvar k = 1; k < 6; k++) begin : g_lvl
        localparam int D = 1 << (k - 1);
        for (genvar i = 0; i < 32; i++) begin : g_bit
            if (i >= D) begin : g_op
                assign g[k][i] = g[k-1][i] | (p[k-1][i] & g[k-1][i-D]);
                assign p[k][i] = p[k-1][i] & p[k-1][i-D];
            end else begin : g_pass
                assign g[k][i] = g[k-1][i];
                assign p[k][i] = p[k-1][i];
            end
        end
    end

    assign c[0] = cIn;
    for (genvar i = 0; i < 32; i++) begin : g_carry
        assign c[i+1] = g[5][i] | (p[5][i] & cIn);
    end

    assign sum  = p[0] ^ c[31:0];
    assign cOut = c[32];

endmodule

module ksa_mp_sequencer #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [LEN_W-1:0] len_m1,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_s,
    output logic             out_last,
    output logic             done,
    output logic             cout,
    output logic             ovf
`ifdef KSA_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic             sub_q, sub_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [31:0]      out_s_q, out_s_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      b_eff;
    logic [31:0]      add_sum;
    logic             add_cout;
    logic             in_hs;
    logic             out_hs;

    assign b_eff = sub_q ? ~in_b : in_b;

    koggestone32bit u_adder (
        .a    (in_a),
        .b    (b_eff),
        .cIn  (carry_q),
        .sum  (add_sum),
        .cOut (add_cout)
    );

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_s_d     = out_s_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        // A draining result word frees the output slot; a new input word may refill it in the same cycle
        if (out_hs) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sub_d   = sub;
                    len_d   = len_m1;
                    cnt_d   = '0;
                    carry_d = sub;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (in_hs) begin
                    out_s_d     = add_sum;
                    carry_d     = add_cout;
                    out_valid_d = 1'b1;
                    if (cnt_q == len_q) begin
                        out_last_d = 1'b1;
                        cout_d     = add_cout;
                        ovf_d      = (in_a[31] == b_eff[31]) && (add_sum[31] != in_a[31]);
                        state_d    = DRAIN;
                    end else begin
                        out_last_d = 1'b0;
                        cnt_d      = cnt_q + LEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    out_last_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef KSA_SEQ_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sub_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_s_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_s_q     <= out_s_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ksa_mp_sequencer.sv
// Self-checking bench for ksa_mp_sequencer: directed vector table, hand sequences for reset/abort,
// and randomized operations compared against a whole-number arithmetic reference model.

module tb_ksa_mp_sequencer;

    localparam int LEN_W = 4;
    localparam int MAXW  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [LEN_W-1:0] len_m1;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_s;
    logic             out_last;
    logic             done;
    logic             cout;
    logic             ovf;
`ifdef KSA_SEQ_ABORT_EN
    logic             abort;
`endif

    ksa_mp_sequencer #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .len_m1    (len_m1),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_last  (out_last),
        .done      (done),
        .cout      (cout),
        .ovf       (ovf)
`ifdef KSA_SEQ_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sub;
        int          len_m1;
        logic [31:0] a0, a1, b0, b1;
        logic [31:0] s0, s1;
        bit          cout;
        bit          ovf;
    } vec_t;

    vec_t        vecs[6];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] op_a[MAXW];
    logic [31:0] op_b[MAXW];
    logic [31:0] exp_s[MAXW];
    logic        exp_cout;
    logic        exp_ovf;
    bit          op_sub;
    int          op_len;
    int          hs_mode;
    int          stall_left;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference: treat operands as (n*32)-bit integers and do one wide add of A + B' + sub
    task automatic computeModel();
        logic [512:0] big_a, big_bp, big_s;
        int           n;
        n      = op_len + 1;
        big_a  = '0;
        big_bp = '0;
        for (int i = 0; i < n; i++) begin
            big_a[i*32 +: 32]  = op_a[i];
            big_bp[i*32 +: 32] = op_sub ? ~op_b[i] : op_b[i];
        end
        big_s = big_a + big_bp + 513'(op_sub);
        for (int i = 0; i < n; i++) begin
            exp_s[i] = big_s[i*32 +: 32];
        end
        exp_cout = big_s[n*32];
        exp_ovf  = (big_a[n*32-1] == big_bp[n*32-1]) && (big_s[n*32-1] != big_a[n*32-1]);
    endtask

    function automatic logic [31:0] randWord();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 32'hFFFF_FFFF;
        if (r == 1) return 32'h0000_0000;
        return $urandom;
    endfunction

    // Runs one full operation: start, stream words in, accept results, then check completion flags
    task automatic applyStimulus();
        int          n;
        int          in_cnt, out_cnt, cyc;
        bit          finished, stalled, full_rate, exp_ov, exp_ir, in_hs, out_hs;
        logic [31:0] hold_s;
        logic        hold_last;
        n         = op_len + 1;
        in_cnt    = 0;
        out_cnt   = 0;
        cyc       = 0;
        finished  = 0;
        stalled   = 0;
        hold_s    = '0;
        hold_last = 1'b0;
        full_rate = (hs_mode == 0) && (stall_left == 0);

        @(negedge clk);
        start     = 1'b1;
        sub       = op_sub;
        len_m1    = LEN_W'(op_len);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start    = (out_cnt < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            sub      = 1'($urandom_range(0, 1));
            len_m1   = LEN_W'($urandom_range(0, MAXW - 1));
            in_valid = (hs_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_a     = (in_cnt < n) ? op_a[in_cnt] : $urandom;
            in_b     = (in_cnt < n) ? op_b[in_cnt] : $urandom;
            if (hs_mode == 0) begin
                out_ready = 1'b1;
                if (stall_left > 0 && in_cnt > out_cnt) begin
                    out_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (cyc == 1) begin
                checkOutput("busy_after_start", busy, 1);
                checkOutput("cout_cleared_at_start", cout, 0);
                checkOutput("ovf_cleared_at_start", ovf, 0);
            end
            if (done) begin
                checkOutput("done_after_last_word", out_cnt, n);
                checkOutput("cout", cout, exp_cout);
                checkOutput("ovf", ovf, exp_ovf);
                checkOutput("busy_at_done", busy, 0);
                checkOutput("out_valid_at_done", out_valid, 0);
                if (full_rate) checkOutput("full_rate_cycles", cyc, n + 2);
                finished = 1;
            end else begin
                exp_ov = (in_cnt > out_cnt);
                exp_ir = (in_cnt < n) && (!exp_ov || out_ready);
                checkOutput("out_valid", out_valid, exp_ov);
                checkOutput("in_ready", in_ready, exp_ir);
                checkOutput("busy", busy, 1);
                if (stalled) begin
                    checkOutput("out_s_stable", out_s, hold_s);
                    checkOutput("out_last_stable", out_last, hold_last);
                end
                if (exp_ov) begin
                    checkOutput("out_s", out_s, exp_s[out_cnt]);
                    checkOutput("out_last", out_last, (out_cnt == n - 1));
                end
                in_hs     = in_valid && exp_ir;
                out_hs    = exp_ov && out_ready;
                stalled   = exp_ov && !out_ready;
                hold_s    = out_s;
                hold_last = out_last;
                if (in_hs)  in_cnt++;
                if (out_hs) out_cnt++;
            end
        end
        if (!finished) begin
            n_fail++;
            $display("[TB] FAIL op_timeout: got no done after %0d cycles, expected done", cyc);
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("cout_hold", cout, exp_cout);
        checkOutput("ovf_hold", ovf, exp_ovf);
    endtask

    initial begin
        vecs[0] = '{0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 32'h0, 32'h0000_0000, 32'h0, 1, 0};
        vecs[1] = '{0, 1, 32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 32'h0, 32'h0000_0000, 32'h1, 0, 0};
        vecs[2] = '{1, 0, 32'h0000_0000, 32'h0, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 32'h0, 0, 0};
        vecs[3] = '{1, 0, 32'h8000_0000, 32'h0, 32'h0000_0001, 32'h0, 32'h7FFF_FFFF, 32'h0, 1, 1};
        vecs[4] = '{0, 0, 32'h7FFF_FFFF, 32'h0, 32'h0000_0001, 32'h0, 32'h8000_0000, 32'h0, 0, 1};
        vecs[5] = '{1, 1, 32'h0000_0000, 32'h0, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};

        rst_n     = 1'b0;
        start     = 1'b0;
        sub       = 1'b0;
        len_m1    = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        hs_mode   = 0;
        stall_left = 0;
`ifdef KSA_SEQ_ABORT_EN
        abort     = 1'b0;
`endif

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_s", out_s, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vector table");
        for (int v = 0; v < 6; v++) begin
            op_sub   = vecs[v].sub;
            op_len   = vecs[v].len_m1;
            op_a[0]  = vecs[v].a0;
            op_a[1]  = vecs[v].a1;
            op_b[0]  = vecs[v].b0;
            op_b[1]  = vecs[v].b1;
            exp_s[0] = vecs[v].s0;
            exp_s[1] = vecs[v].s1;
            exp_cout = vecs[v].cout;
            exp_ovf  = vecs[v].ovf;
            hs_mode  = 0;
            stall_left = 0;
            applyStimulus();
        end

        $display("[TB] backpressure on a 4-word add");
        op_sub = 0;
        op_len = 3;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 32'h8000_0000 + 32'(i);
            op_b[i] = 32'h8000_0001 + 32'(i);
        end
        computeModel();
        hs_mode    = 0;
        stall_left = 3;
        applyStimulus();

        $display("[TB] reset in the middle of a 4-word operation");
        @(negedge clk);
        start  = 1'b1;
        sub    = 1'b0;
        len_m1 = LEN_W'(3);
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_a      = 32'h1111_1111;
        in_b      = 32'h2222_2222;
        @(negedge clk);
        in_a = 32'h3333_3333;
        in_b = 32'h4444_4444;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_s", out_s, 0);
        checkOutput("midrst_out_last", out_last, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_cout", cout, 0);
        checkOutput("midrst_ovf", ovf, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput("midrst_no_done", done, 0);
            checkOutput("midrst_idle", busy, 0);
        end
        op_sub   = 0;
        op_len   = 0;
        op_a[0]  = 32'd2;
        op_b[0]  = 32'd3;
        exp_s[0] = 32'd5;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        hs_mode  = 0;
        stall_left = 0;
        applyStimulus();

`ifdef KSA_SEQ_ABORT_EN
        $display("[TB] abort after first word of three");
        @(negedge clk);
        start  = 1'b1;
        sub    = 1'b0;
        len_m1 = LEN_W'(2);
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_a      = 32'h5;
        in_b      = 32'h6;
        @(negedge clk);
        in_a  = 32'h7;
        in_b  = 32'h8;
        abort = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_out_last", out_last, 0);
        checkOutput("abort_in_ready", in_ready, 0);
        checkOutput("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("abort_no_done", done, 0);
        end
`endif

        $display("[TB] randomized operations");
        for (int t = 0; t < 40; t++) begin
            op_sub = 1'($urandom_range(0, 1));
            op_len = $urandom_range(0, MAXW - 1);
            for (int i = 0; i < MAXW; i++) begin
                op_a[i] = randWord();
                op_b[i] = randWord();
            end
            computeModel();
            hs_mode    = $urandom_range(0, 1);
            stall_left = (hs_mode == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa_mp_sequencer.md
KSA_MP_SEQUENCER -- requirements
Module: ksa_mp_sequencer

Interface
REQ-001 The block SHALL have parameter LEN_W, default 4: width of the word-count field; max operand length 2^LEN_W words.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  begin operation; sampled only in IDLE.
REQ-006 sub  in  1  operation select, latched at start: 0 = A+B, 1 = A-B.
REQ-007 len_m1  in  LEN_W  operand length in 32-bit words minus one, latched at start.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 in_valid  in  1  operand word pair present.
REQ-010 in_ready  out  1  block accepts operand word pair.
REQ-011 in_a, in_b  in  32 each  operand words, least-significant word first.
REQ-012 out_valid  out  1  result word present.
REQ-013 out_ready  in  1  consumer accepts result word.
REQ-014 out_s  out  32  result word.
REQ-015 out_last  out  1  out_s is the most-significant result word.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 cout  out  1  raw carry out of the most-significant word; for sub, 1 = no borrow.
REQ-018 ovf  out  1  two's-complement signed overflow of the full-length result.

Function
REQ-019 The block SHALL instantiate exactly one koggestone32bit adder and time-share it across all words of an operation.
REQ-020 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-021 Transition IDLE->RUN SHALL occur on start=1: latch sub and len_m1, clear the word counter, load the carry register with sub. start in RUN or DRAIN SHALL be ignored.
REQ-022 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready); an input handshake is in_valid && in_ready.
REQ-023 On each input handshake, the adder SHALL be driven with a=in_a, b=(sub ? ~in_b : in_b), cIn=carry register. Its sum SHALL be registered to out_s, and its carry out registered to the carry register, with out_valid=1 on the next cycle (latency 1).
REQ-024 Full throughput SHALL be supported: one word per cycle when out_ready is held high, including a simultaneous output handshake and input handshake.
REQ-025 out_s and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 On the handshake of word index len_m1: out_last=1; cout=adder carry out; ovf=(a[31]==b'[31]) && (sum[31]!=a[31]), where b' is the inverted-or-not B; transition RUN->DRAIN.
REQ-027 DRAIN->IDLE SHALL occur on the output handshake of the last word. done SHALL pulse high for exactly one cycle, in the cycle after that handshake.
REQ-028 cout and ovf SHALL hold their values until the next accepted start. At that start they SHALL be cleared to 0.
REQ-029 With len_m1=0, the block SHALL perform a single-word operation, with first word = last word.
REQ-030 The word counter SHALL be LEN_W bits and SHALL never wrap within an operation.

Reset
REQ-031 While rst_n=0, all of the following SHALL apply: state=IDLE; busy, in_ready, out_valid, out_last, done, cout and ovf = 0; out_s=0; carry register, counter, sub and len_m1 registers = 0.
REQ-032 Reset asserted mid-operation SHALL discard the operation with no done pulse. The first start after release SHALL behave as from power-up.

Configuration
REQ-033 When KSA_SEQ_ABORT_EN is defined, an input port abort (in, 1) SHALL exist. abort=1 in RUN or DRAIN SHALL force IDLE on the next edge, clear out_valid and out_last, and produce no done pulse. abort in IDLE SHALL have no effect. abort SHALL take priority over a same-cycle handshake.
REQ-034 When KSA_SEQ_ABORT_EN is undefined, the abort port and its logic SHALL be absent.

Verification
REQ-035 Single-word add: len_m1=0, sub=0, a=0xFFFFFFFF, b=0x00000001 -> out_s=0x00000000, out_last=1, cout=1, ovf=0, done pulse 1 cycle after the output handshake.
REQ-036 Two-word carry chain: a={0xFFFFFFFF, 0x00000000}, b={0x00000001, 0x00000000} (LSW first) -> out_s=0x00000000 then 0x00000001, cout=0, ovf=0.
REQ-037 Subtract: sub=1, len_m1=0, a=0x00000000, b=0x00000001 -> out_s=0xFFFFFFFF, cout=0, ovf=0. Then a=0x80000000, b=0x00000001 -> out_s=0x7FFFFFFF, cout=1, ovf=1.
REQ-038 Backpressure: 4-word add with out_ready=0 for 3 cycles after the first result -> in_ready=0 throughout, out_s unchanged. Resuming yields correct words at 1 word/cycle.
REQ-039 Reset mid-op: rst_n low during word 2 of 4 -> all outputs 0, no done pulse. A subsequent 1-word add of 2+3 returns 0x00000005.
REQ-040 With KSA_SEQ_ABORT_EN: abort after word 1 of 3 -> IDLE next cycle, out_valid=0, no done pulse, busy=0.
